// File: rtl/fpu_pkg.sv
`default_nettype none
// ============================================================================
//  Module      : fpu_pkg
//  Description : IEEE-754 single-precision field layout, the float32 type and
//                a denormal flush helper shared by the operand feeder.
//  Revision    : 1.0 - initial release
// ============================================================================
package fpu_pkg;

    localparam int EXP_W    = 8;
    localparam int MANT_W   = 23;
    localparam int EXP_BIAS = 127;

    // Bit positions of the fields inside a 32-bit word
    localparam int SIGN_BIT = 31;
    localparam int EXP_MSB  = 30;
    localparam int EXP_LSB  = 23;
    localparam int MANT_MSB = 22;
    localparam int MANT_LSB = 0;

    typedef struct packed {
        logic              sign;
        logic [EXP_W-1:0]  exp;
        logic [MANT_W-1:0] mant;
    } float32_t;

    // Denormals (zero exponent, nonzero mantissa) become a zero of the same sign
    function automatic float32_t flush_denorm(input float32_t x);
        float32_t r;
        r = x;
        if ((x.exp == '0) && (x.mant != '0)) begin
            r.exp  = '0;
            r.mant = '0;
        end
        return r;
    endfunction

endpackage
`default_nettype wire

// File: rtl/fpu_pair_fifo.sv
`default_nettype none
// ============================================================================
//  Module      : fpu_pair_fifo
//  Description : 64-bit wide FIFO holding {A,B} operand pairs. Push is ignored
//                when full and pop when empty; simultaneous push/pop keeps the
//                occupancy unchanged. Head entry is presented combinationally.
//  Revision    : 1.0 - initial release
// ============================================================================
module fpu_pair_fifo #(
    parameter int DEPTH = 4
) (
    input  logic                       clk,
    input  logic                       rst,
    input  logic                       push_i,
    input  logic [63:0]                wdata_i,
    input  logic                       pop_i,
    output logic [63:0]                rdata_o,
    output logic [$clog2(DEPTH):0]     count_o
);

    localparam int PTR_W = $clog2(DEPTH);
    localparam int CNT_W = PTR_W + 1;
    localparam logic [CNT_W-1:0] FULL_CNT = CNT_W'(DEPTH);

    logic [63:0]      mem_q [DEPTH];
    logic [PTR_W-1:0] wr_ptr_q;
    logic [PTR_W-1:0] rd_ptr_q;
    logic [CNT_W-1:0] count_q;
    logic             w_push;
    logic             w_pop;

    assign w_push  = push_i && (count_q != FULL_CNT);
    assign w_pop   = pop_i  && (count_q != '0);
    assign rdata_o = mem_q[rd_ptr_q];
    assign count_o = count_q;

    // Storage array: data only, validity is tracked by the pointers
    always_ff @(posedge clk) begin
        if (w_push) begin
            mem_q[wr_ptr_q] <= wdata_i;
        end
    end

    // Pointer and occupancy bookkeeping; pointers wrap since DEPTH is a power of two
    always_ff @(posedge clk) begin
        if (rst) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            count_q  <= '0;
        end else begin
            if (w_push) wr_ptr_q <= wr_ptr_q + 1'b1;
            if (w_pop)  rd_ptr_q <= rd_ptr_q + 1'b1;
            case ({w_push, w_pop})
                2'b10:   count_q <= count_q + 1'b1;
                2'b01:   count_q <= count_q - 1'b1;
                default: count_q <= count_q;
            endcase
        end
    end

endmodule
`default_nettype wire

// File: rtl/fpu_operand_feeder.sv
`default_nettype none
// ============================================================================
//  Module      : fpu_operand_feeder
//  Description : Buffers {A,B} operand pairs and hands each pair to a
//                multiplier over two strobe/ack channels, A first then B.
//                Optional macro FEEDER_FTZ_EN flushes denormal operands to
//                signed zero as they are latched onto the output registers.
//  Revision    : 1.0 - initial release
// ============================================================================
module fpu_operand_feeder
    import fpu_pkg::*;
#(
    parameter int DEPTH = 4
) (
    input  logic                   clk,
    input  logic                   rst,
    input  logic [31:0]            in_a,
    input  logic [31:0]            in_b,
    input  logic                   in_valid,
    output logic                   in_ready,
    output logic [31:0]            out_a,
    output logic                   out_a_stb,
    input  logic                   out_a_ack,
    output logic [31:0]            out_b,
    output logic                   out_b_stb,
    input  logic                   out_b_ack,
    output logic [$clog2(DEPTH):0] count,
    output logic                   busy,
    output logic [15:0]            pairs_sent
);

    localparam int CNT_W = $clog2(DEPTH) + 1;
    localparam logic [CNT_W-1:0] FULL_CNT = CNT_W'(DEPTH);

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        SEND_A = 2'd1,
        SEND_B = 2'd2
    } state_t;

    state_t      state_q;
    float32_t    out_a_q;
    float32_t    out_b_q;
    logic        out_a_stb_q;
    logic        out_b_stb_q;
    logic [15:0] pairs_sent_q;

    logic [63:0] w_head;
    logic        w_push;
    logic        w_pop;
    float32_t    a_d;
    float32_t    b_d;

    assign in_ready = (count < FULL_CNT);
    assign w_push   = in_valid && in_ready && !rst;
    // The FSM consumes the head exactly when it latches it in IDLE
    assign w_pop    = (state_q == IDLE) && (count != '0) && !rst;

    fpu_pair_fifo #(
        .DEPTH (DEPTH)
    ) u_fifo (
        .clk     (clk),
        .rst     (rst),
        .push_i  (w_push),
        .wdata_i ({in_a, in_b}),
        .pop_i   (w_pop),
        .rdata_o (w_head),
        .count_o (count)
    );

`ifdef FEEDER_FTZ_EN
    assign a_d = flush_denorm(float32_t'(w_head[63:32]));
    assign b_d = flush_denorm(float32_t'(w_head[31:0]));
`else
    assign a_d = float32_t'(w_head[63:32]);
    assign b_d = float32_t'(w_head[31:0]);
`endif

    // Transfer FSM: latch a pair, hand out A, then B, then return to IDLE
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q      <= IDLE;
            out_a_q      <= '0;
            out_b_q      <= '0;
            out_a_stb_q  <= 1'b0;
            out_b_stb_q  <= 1'b0;
            pairs_sent_q <= '0;
        end else begin
            case (state_q)
                IDLE: begin
                    if (count != '0) begin
                        out_a_q     <= a_d;
                        out_b_q     <= b_d;
                        out_a_stb_q <= 1'b1;
                        state_q     <= SEND_A;
                    end
                end
                SEND_A: begin
                    if (out_a_stb_q && out_a_ack) begin
                        out_a_stb_q <= 1'b0;
                        out_b_stb_q <= 1'b1;
                        state_q     <= SEND_B;
                    end
                end
                SEND_B: begin
                    if (out_b_stb_q && out_b_ack) begin
                        out_b_stb_q  <= 1'b0;
                        pairs_sent_q <= pairs_sent_q + 16'd1;
                        state_q      <= IDLE;
                    end
                end
                default: begin
                    state_q     <= IDLE;
                    out_a_stb_q <= 1'b0;
                    out_b_stb_q <= 1'b0;
                end
            endcase
        end
    end

    assign out_a      = out_a_q;
    assign out_b      = out_b_q;
    assign out_a_stb  = out_a_stb_q;
    assign out_b_stb  = out_b_stb_q;
    assign busy       = (state_q != IDLE);
    assign pairs_sent = pairs_sent_q;

endmodule
`default_nettype wire

// File: tb/tb_fpu_operand_feeder.sv
`default_nettype none
// ============================================================================
//  Module      : tb_fpu_operand_feeder
//  Description : Self-checking bench for fpu_operand_feeder (DEPTH=4).
//                Table-driven single-pair vectors, hand-written corner
//                sequences and random traffic against a queue-based model.
//  Revision    : 1.0 - initial release
// ============================================================================
module tb_fpu_operand_feeder;

    localparam int DEPTH = 4;

    logic        clk = 1'b0;
    logic        rst;
    logic [31:0] in_a, in_b;
    logic        in_valid;
    logic        in_ready;
    logic [31:0] out_a, out_b;
    logic        out_a_stb, out_b_stb;
    logic        out_a_ack, out_b_ack;
    logic [2:0]  count;
    logic        busy;
    logic [15:0] pairs_sent;

    fpu_operand_feeder #(.DEPTH(DEPTH)) dut (
        .clk        (clk),
        .rst        (rst),
        .in_a       (in_a),
        .in_b       (in_b),
        .in_valid   (in_valid),
        .in_ready   (in_ready),
        .out_a      (out_a),
        .out_a_stb  (out_a_stb),
        .out_a_ack  (out_a_ack),
        .out_b      (out_b),
        .out_b_stb  (out_b_stb),
        .out_b_ack  (out_b_ack),
        .count      (count),
        .busy       (busy),
        .pairs_sent (pairs_sent)
    );

    always #5 clk = ~clk;

    int          n_checks = 0;
    int          n_fail   = 0;
    logic [63:0] model_q[$];
    int          m_sent   = 0;

    typedef struct {
        logic [31:0] a;
        logic [31:0] b;
        logic [31:0] ftz_a;
        logic [31:0] ftz_b;
    } vec_t;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%08h expected 0x%08h at %0t", name, act, exp, $time);
        end
    endtask

    // Expected operand as seen by the multiplier
    function automatic logic [31:0] exp_op(input logic [31:0] x);
`ifdef FEEDER_FTZ_EN
        if ((x & 32'h7F80_0000) == 0 && (x & 32'h007F_FFFF) != 0)
            return x & 32'h8000_0000;
`endif
        return x;
    endfunction

    // One clock: record what crosses the edge, advance, then check invariants
    task automatic tick();
        logic        pa, pb, xa, xb, r;
        logic [31:0] oa, ob;
        pa = out_a_stb; pb = out_b_stb; oa = out_a; ob = out_b; r = rst;
        xa = pa && out_a_ack;
        xb = pb && out_b_ack;
        if (r) begin
            model_q.delete();
            m_sent = 0;
        end else begin
            if (in_valid && in_ready) model_q.push_back({in_a, in_b});
            if (xa) begin
                if (model_q.size() == 0) check("a_unexpected", 1, 0);
                else check("a_data", oa, exp_op(model_q[0][63:32]));
            end
            if (xb) begin
                if (model_q.size() == 0) check("b_unexpected", 1, 0);
                else begin
                    check("b_data", ob, exp_op(model_q[0][31:0]));
                    void'(model_q.pop_front());
                end
                m_sent = (m_sent + 1) % 65536;
            end
        end
        @(posedge clk);
        #1;
        check("stb_exclusive", {31'b0, out_a_stb & out_b_stb}, 0);
        check("in_ready", {31'b0, in_ready}, {31'b0, (count < DEPTH)});
        check("pairs_sent", {16'b0, pairs_sent}, m_sent);
        if (r) begin
            check("rst_a_stb", {31'b0, out_a_stb}, 0);
            check("rst_b_stb", {31'b0, out_b_stb}, 0);
            check("rst_count", {29'b0, count}, 0);
        end else begin
            if (pa && !xa) check("a_stb_hold", {31'b0, out_a_stb}, 1);
            if (pb && !xb) check("b_stb_hold", {31'b0, out_b_stb}, 1);
            if (xa) check("b_stb_after_a", {30'b0, out_a_stb, out_b_stb}, 1);
            if (xb) check("idle_gap", {30'b0, out_a_stb, out_b_stb}, 0);
            if ((pa || pb) && (out_a_stb || out_b_stb)) begin
                check("out_a_stable", out_a, oa);
                check("out_b_stable", out_b, ob);
            end
        end
    endtask

    task automatic do_reset();
        rst = 1'b1; in_valid = 1'b0; out_a_ack = 1'b0; out_b_ack = 1'b0;
        in_a = '0; in_b = '0;
        tick(); tick();
        rst = 1'b0;
    endtask

    // Drive acks high until the model is empty and the FSM is idle
    task automatic drain();
        in_valid = 1'b0;
        out_a_ack = 1'b1; out_b_ack = 1'b1;
        for (int i = 0; i < 200 && (model_q.size() != 0 || busy); i++) tick();
        out_a_ack = 1'b0; out_b_ack = 1'b0;
        check("drain_left", model_q.size(), 0);
        check("drain_busy", {31'b0, busy}, 0);
        check("drain_count", {29'b0, count}, 0);
    endtask

    task automatic run_pair(input logic [31:0] a, input logic [31:0] b,
                            input logic [31:0] ea, input logic [31:0] eb);
        int s0;
        s0 = m_sent;
        in_valid = 1'b1; in_a = a; in_b = b;
        tick();
        in_valid = 1'b0;
        check("lat_count", {29'b0, count}, 1);
        check("lat_a_stb_early", {31'b0, out_a_stb}, 0);
        tick();
        check("lat_a_stb", {31'b0, out_a_stb}, 1);
        check("vec_out_a", out_a, ea);
        check("vec_busy", {31'b0, busy}, 1);
        check("vec_count_popped", {29'b0, count}, 0);
        out_a_ack = 1'b1;
        tick();
        out_a_ack = 1'b0;
        check("vec_b_stb", {30'b0, out_a_stb, out_b_stb}, 1);
        check("vec_out_b", out_b, eb);
        out_b_ack = 1'b1;
        tick();
        out_b_ack = 1'b0;
        check("vec_done_stb", {30'b0, out_a_stb, out_b_stb}, 0);
        check("vec_done_busy", {31'b0, busy}, 0);
        check("vec_sent", {16'b0, pairs_sent}, (s0 + 1) % 65536);
        tick();
    endtask

    initial begin
        #2_000_000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1);
    end

    initial begin
        vec_t vecs[6];
        int   accepted, ha, hb;

        vecs[0] = '{32'h3F80_0000, 32'h4000_0000, 32'h3F80_0000, 32'h4000_0000};
        vecs[1] = '{32'h0000_0001, 32'h8040_0000, 32'h0000_0000, 32'h8000_0000};
        vecs[2] = '{32'h7F80_0000, 32'hFF80_0000, 32'h7F80_0000, 32'hFF80_0000};
        vecs[3] = '{32'h0000_0000, 32'h8000_0000, 32'h0000_0000, 32'h8000_0000};
        vecs[4] = '{32'h807F_FFFF, 32'h0080_0000, 32'h8000_0000, 32'h0080_0000};
        vecs[5] = '{32'h7FC0_0000, 32'hC049_0FDB, 32'h7FC0_0000, 32'hC049_0FDB};

        // Reset state
        do_reset();
        check("reset_count", {29'b0, count}, 0);
        check("reset_stbs", {30'b0, out_a_stb, out_b_stb}, 0);
        check("reset_out_a", out_a, 0);
        check("reset_out_b", out_b, 0);
        check("reset_busy", {31'b0, busy}, 0);
        check("reset_sent", {16'b0, pairs_sent}, 0);
        check("reset_in_ready", {31'b0, in_ready}, 1);

        // Table-driven single pairs
        for (int i = 0; i < 6; i++) begin
`ifdef FEEDER_FTZ_EN
            run_pair(vecs[i].a, vecs[i].b, vecs[i].ftz_a, vecs[i].ftz_b);
`else
            run_pair(vecs[i].a, vecs[i].b, vecs[i].a, vecs[i].b);
`endif
        end
        check("table_sent", {16'b0, pairs_sent}, 6);

        // Fill: 5 pairs with acks low -> 1 latched, 4 buffered
        do_reset();
        accepted = 0;
        for (int i = 0; i < 20 && accepted < 5; i++) begin
            in_valid = 1'b1;
            in_a = 32'h4100_0000 + accepted; in_b = 32'h4200_0000 + accepted;
            if (in_ready) accepted++;
            tick();
        end
        in_valid = 1'b0;
        check("fill_accepted", accepted, 5);
        check("fill_in_ready", {31'b0, in_ready}, 0);
        check("fill_count", {29'b0, count}, 4);
        check("fill_stbs", {30'b0, out_a_stb, out_b_stb}, 2);
        check("fill_head_a", out_a, 32'h4100_0000);
        tick();
        check("fill_count_hold", {29'b0, count}, 4);
        drain();
        check("fill_sent", {16'b0, pairs_sent}, 5);

        // Acks delayed: each strobe held 3 cycles before its ack
        do_reset();
        accepted = 0; ha = 0; hb = 0;
        for (int i = 0; i < 200 && (accepted < 8 || model_q.size() != 0 || busy); i++) begin
            in_valid = (accepted < 8);
            in_a = $urandom; in_b = $urandom;
            if (in_valid && in_ready) accepted++;
            out_a_ack = (ha >= 3);
            out_b_ack = (hb >= 3);
            tick();
            ha = out_a_stb ? ha + 1 : 0;
            hb = out_b_stb ? hb + 1 : 0;
        end
        in_valid = 1'b0; out_a_ack = 1'b0; out_b_ack = 1'b0;
        check("slow_sent", {16'b0, pairs_sent}, 8);
        check("slow_left", model_q.size(), 0);

        // Push at count==DEPTH-1 coinciding with the IDLE pop
        do_reset();
        for (int i = 0; i < 4; i++) begin
            in_valid = 1'b1; in_a = 32'h3000_0000 + i; in_b = 32'h3100_0000 + i;
            tick();
        end
        in_valid = 1'b0;
        check("pp_count3", {29'b0, count}, 3);
        out_a_ack = 1'b1; tick(); out_a_ack = 1'b0;
        out_b_ack = 1'b1; tick(); out_b_ack = 1'b0;
        check("pp_idle", {31'b0, busy}, 0);
        check("pp_count_idle", {29'b0, count}, 3);
        in_valid = 1'b1; in_a = 32'h3000_0004; in_b = 32'h3100_0004;
        tick();
        in_valid = 1'b0;
        check("pp_count_same", {29'b0, count}, 3);
        check("pp_a_stb", {31'b0, out_a_stb}, 1);
        check("pp_head", out_a, 32'h3000_0001);
        drain();
        check("pp_sent", {16'b0, pairs_sent}, 5);

        // Reset while in SEND_B with 3 pairs buffered
        do_reset();
        for (int i = 0; i < 4; i++) begin
            in_valid = 1'b1; in_a = $urandom; in_b = $urandom;
            tick();
        end
        in_valid = 1'b0;
        out_a_ack = 1'b1; tick(); out_a_ack = 1'b0;
        check("rb_in_send_b", {30'b0, out_a_stb, out_b_stb}, 1);
        check("rb_count", {29'b0, count}, 3);
        rst = 1'b1; out_b_ack = 1'b1;
        in_valid = 1'b1; in_a = 32'h1234_5678; in_b = 32'h9ABC_DEF0;
        tick();
        rst = 1'b0; in_valid = 1'b0; out_b_ack = 1'b0;
        check("rb_stbs", {30'b0, out_a_stb, out_b_stb}, 0);
        check("rb_count0", {29'b0, count}, 0);
        check("rb_sent0", {16'b0, pairs_sent}, 0);
        out_a_ack = 1'b1; out_b_ack = 1'b1;
        for (int i = 0; i < 10; i++) begin
            tick();
            check("rb_quiet", {30'b0, out_a_stb, out_b_stb}, 0);
        end
        out_a_ack = 1'b0; out_b_ack = 1'b0;

        // Random traffic with random acks and occasional denormals
        do_reset();
        for (int i = 0; i < 400; i++) begin
            in_valid  = ($urandom_range(0, 2) != 0);
            in_a      = $urandom; in_b = $urandom;
            if ($urandom_range(0, 3) == 0) in_a = $urandom & 32'h807F_FFFF;
            if ($urandom_range(0, 3) == 0) in_b = $urandom & 32'h807F_FFFF;
            out_a_ack = ($urandom_range(0, 2) == 0);
            out_b_ack = ($urandom_range(0, 2) == 0);
            tick();
        end
        drain();

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
`default_nettype wire

// File: doc/fpu_operand_feeder.md
FPU_OPERAND_FEEDER -- requirements
Module: fpu_operand_feeder

Interface
REQ-001 SHALL have parameter DEPTH, default 4, pair-buffer entries (power of two, >=2).
REQ-002 SHALL use reset rst, synchronous, active-high; clock clk.
REQ-003 Ports SHALL be, one per line:
  clk  input  1  clock
  rst  input  1  synchronous active-high reset
  in_a  input  32  operand A (IEEE-754 single)
  in_b  input  32  operand B (IEEE-754 single)
  in_valid  input  1  pair offered
  in_ready  output  1  pair accepted when in_valid&in_ready at edge
  out_a  output  32  operand A to multiplier
  out_a_stb  output  1  out_a valid
  out_a_ack  input  1  multiplier accepts A
  out_b  output  32  operand B to multiplier
  out_b_stb  output  1  out_b valid
  out_b_ack  input  1  multiplier accepts B
  count  output  $clog2(DEPTH)+1  pairs buffered
  busy  output  1  transfer in progress
  pairs_sent  output  16  completed pair transfers

Function
REQ-004 Pair buffer SHALL be FIFO order; in_ready = (count < DEPTH), combinational from count.
REQ-005 Push and pop in the same cycle SHALL leave count unchanged; no push when count==DEPTH.
REQ-006 FSM states SHALL be IDLE, SEND_A, SEND_B; busy = (state != IDLE).
REQ-007 IDLE with count!=0: SHALL latch head pair into out_a/out_b, pop, set out_a_stb=1, go SEND_A.
REQ-008 SEND_A: transfer at edge with out_a_stb&out_a_ack; then out_a_stb<=0, out_b_stb<=1, go SEND_B.
REQ-009 SEND_B: transfer at edge with out_b_stb&out_b_ack; then out_b_stb<=0, pairs_sent+1, go IDLE.
REQ-010 Stb SHALL stay high until its transfer; out_a/out_b SHALL be stable while either stb is high.
REQ-011 Ack without matching stb SHALL be ignored; out_a_stb and out_b_stb never high together.
REQ-012 Latency: pair pushed at edge k with empty buffer and idle FSM -> out_a_stb high after edge k+1.
REQ-013 Back-to-back pairs SHALL have one IDLE cycle between B transfer and next out_a_stb.
REQ-014 pairs_sent SHALL wrap 0xFFFF -> 0x0000.

Reset
REQ-015 rst SHALL force state IDLE, count 0, buffer pointers 0, out_a_stb 0, out_b_stb 0, pairs_sent 0, out_a/out_b 0.
REQ-016 rst mid-transfer SHALL drop stb next edge and discard all buffered and in-flight pairs.
REQ-017 Pushes in a cycle where rst is high SHALL be discarded.

Configuration
REQ-018 With FEEDER_FTZ_EN defined: operand with exponent field 0 and nonzero mantissa SHALL be replaced by {sign, 31'b0} when latched into out_a/out_b (REQ-007).
REQ-019 Without FEEDER_FTZ_EN: operands SHALL pass bit-exact.

Structure
REQ-020 Package fpu_pkg SHALL hold float32 typedef, EXP_W=8, MANT_W=23, EXP_BIAS=127, field slice constants.
REQ-021 Pair storage SHALL be sub-module fpu_pair_fifo (64-bit wide, DEPTH entries, count output).

Verification
REQ-022 Push (0x3F800000,0x40000000), ack one cycle after stb -> out_a=0x3F800000 then out_b=0x40000000, pairs_sent=1, count back to 0.
REQ-023 Push 5 pairs at DEPTH=4 with acks held low -> in_ready low after 5th accepted (4 buffered + 1 latched), count=4, only out_a_stb high.
REQ-024 Acks delayed 3 cycles each -> out_a/out_b held stable, stb held, no duplicate or lost pairs over 8 pairs; FIFO order preserved.
REQ-025 Push at count==DEPTH-1 in same cycle as pop -> count unchanged, both pairs delivered in order.
REQ-026 rst asserted in SEND_B with 3 pairs buffered -> next edge stbs 0, count 0, pairs_sent 0; no further transfers.
REQ-027 Push (0x00000001,0x80400000) -> with FEEDER_FTZ_EN out_a=0x00000000, out_b=0x80000000; without, unchanged.
